// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: state encoding and baud constants shared by the UART blocks. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int CLKS_PER_BIT_115200 = 434;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff: two-flop synchronizer with selectable reset value. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receive.sv
// ---------------------------------------------------------------------------
// uart_receive: 8N1 UART receiver with one-entry valid/ready output. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_receive
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int DATA_BITS    = 8,
  parameter int CNT_W        = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]       c_bit_last = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 w_accept;
  logic                 w_cnt_last;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  assign w_accept   = valid_q & i_ready;
  assign w_cnt_last = (cnt_q == c_cnt_last);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= c_st_idle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  // hold_q keeps IDLE from arming while the line is still low after a bad stop bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (!hold_q && !rx_s) state_d = c_st_start;
      c_st_start: if (cnt_q == c_cnt_half) state_d = rx_s ? c_st_idle : c_st_data;
      c_st_data:  if (w_cnt_last && bit_q == c_bit_last) state_d = c_st_stop;
      c_st_stop:  if (w_cnt_last) state_d = c_st_idle;
      default:    state_d = c_st_idle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = w_accept ? 1'b0 : valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    hold_d  = hold_q;
    busy_d  = (state_d != c_st_idle);
    case (state_q)
      c_st_idle: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_s) hold_d = 1'b0;
      end
      c_st_start: begin
        cnt_d = (cnt_q == c_cnt_half) ? '0 : cnt_q + 1'b1;
      end
      c_st_data: begin
        if (w_cnt_last) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_st_stop: begin
        if (w_cnt_last) begin
          cnt_d = '0;
          if (rx_s) begin
            // A same-cycle accept frees the register, giving gapless validity
            if (!valid_q || i_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
            hold_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receive.sv
// ---------------------------------------------------------------------------
// tb_uart_receive: scoreboard bench for uart_receive at 115200 baud. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_receive;

  localparam int CPB     = 434;
  localparam int DB      = 8;
  localparam int HALF    = (CPB - 1) / 2;
  localparam int LAT_NOM = 2 + HALF + (DB + 1) * CPB + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int valid_rises = 0, ferr_cycles = 0, busy_cycles = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  int t0, r0, f0, b0, lat, lat_meas;
  logic [7:0] rb;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receive #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .CNT_W        (9)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rx        (rx),
    .i_ready     (ready),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_overrun   (ovr),
    .o_busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (valid && !prev_valid) begin
        valid_rises++;
        rise_cyc = cyc;
      end
      if (ferr) ferr_cycles++;
      if (busy) busy_cycles++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", data);
        end else begin
          chk("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_valid = valid;
    end
  end

  // All line drivers start and end just after a rising edge
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_overrun", {31'd0, ovr}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    idle(20);

    // 0xA5 with consumer ready: single valid cycle at the nominal latency
    t0 = cyc; r0 = valid_rises; f0 = ferr_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(CPB);
    lat = rise_cyc - t0;
    lat_meas = lat;
    checks++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
      fails++;
      $display("FAIL a5_latency: got %0d cycles, expected %0d +/-1", lat, LAT_NOM);
    end
    chk("a5_valid_rises", valid_rises - r0, 1);
    chk("a5_no_ferr", ferr_cycles - f0, 0);
    chk("a5_no_overrun", {31'd0, ovr}, 32'd0);

    // 0x55 with a low stop bit, line held low one more bit, then 0x0F
    f0 = ferr_cycles; r0 = valid_rises;
    send_frame(8'h55, 1'b0);
    drive_bit(1'b0);
    idle(2 * CPB);
    chk("ferr_one_cycle", ferr_cycles - f0, 1);
    chk("ferr_no_valid", valid_rises - r0, 0);
    chk("ferr_data_kept", {24'd0, data}, 32'hA5);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(CPB);
    chk("after_ferr_rx", valid_rises - r0, 1);

    // 100-clock glitch on an idle line
    b0 = busy_cycles; r0 = valid_rises; f0 = ferr_cycles;
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(2 * CPB);
    checks++;
    if (busy_cycles - b0 < 100 || busy_cycles - b0 > HALF + 3) begin
      fails++;
      $display("FAIL glitch_busy: got %0d busy cycles, expected 100..%0d", busy_cycles - b0, HALF + 3);
    end
    chk("glitch_no_valid", valid_rises - r0, 0);
    chk("glitch_no_ferr", ferr_cycles - f0, 0);
    chk("glitch_idle", {31'd0, busy}, 32'd0);

    // Hold 0x34, accept it on the very cycle 0x12 completes
    ready = 1'b0;
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    idle(CPB);
    chk("hold_valid", {31'd0, valid}, 32'd1);
    chk("hold_data", {24'd0, data}, 32'h34);
    r0 = valid_rises;
    exp_q.push_back(8'h12);
    fork
      send_frame(8'h12, 1'b1);
      begin
        repeat (lat_meas - 1) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
      end
    join
    idle(CPB);
    chk("b2b_no_gap", valid_rises - r0, 0);
    chk("b2b_valid", {31'd0, valid}, 32'd1);
    chk("b2b_data", {24'd0, data}, 32'h12);
    chk("b2b_no_overrun", {31'd0, ovr}, 32'd0);
    pulse_ready();
    idle(2);
    chk("b2b_drained", {31'd0, valid}, 32'd0);

    // 0x3C then 0xC3 with a 1-bit gap and no consumer: second byte lost
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(CPB);
    send_frame(8'hC3, 1'b1);
    idle(CPB);
    chk("ovr_flag", {31'd0, ovr}, 32'd1);
    chk("ovr_data_kept", {24'd0, data}, 32'h3C);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    pulse_ready();
    idle(2);
    chk("ovr_valid_cleared", {31'd0, valid}, 32'd0);
    chk("ovr_sticky", {31'd0, ovr}, 32'd1);

    // Reset in the middle of data bit 4 of 0xFF
    ready = 1'b1;
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, data}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_ferr", {31'd0, ferr}, 32'd0);
    chk("mid_rst_overrun", {31'd0, ovr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    f0 = ferr_cycles;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(CPB);

    // Random bytes with random idle gaps, consumer always ready
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      exp_q.push_back(rb);
      send_frame(rb, 1'b1);
      idle($urandom_range(1, 300));
    end
    idle(CPB);
    for (int w = 0; w < 5000 && exp_q.size() != 0; w++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_no_overrun", {31'd0, ovr}, 32'd0);
    chk("final_no_ferr", ferr_cycles - f0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
